// File: rtl/pwm_pkg.sv
// Shared definitions for the 10-step PWM generator and its capture counterpart.
package pwm_pkg;

  localparam int unsigned PWM_PERIOD = 10;
  localparam int unsigned DUTY_MIN   = 1;
  localparam int unsigned DUTY_MAX   = 8;
  localparam int unsigned CODE_W     = 3;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } pwm_state_e;

  // High time that maps onto a legal switch code.
  function automatic logic duty_in_range(input int unsigned high);
    return (high >= DUTY_MIN) && (high <= DUTY_MAX);
  endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the asynchronous PWM input, with rising-edge detect.
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise_c
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= pwm_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level  = s2;
  assign rise_c = s2 & ~prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input and decodes the duty level to a 3-bit code.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned PERIOD_NOM = PWM_PERIOD,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  input  logic              en,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CODE_W-1:0] duty_code,
  output logic              meas_valid,
  output logic              err,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] NOM     = CNT_W'(PERIOD_NOM);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_HOLD = CNT_W'(TIMEOUT);

  pwm_state_e state_q, state_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0]  period_d, high_d;
  logic [CODE_W-1:0] code_d;
  logic              valid_d, err_d, timeout_d;
  logic              pwm_lvl, pwm_rise;
  logic              meas_ok;

  pwm_in_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (pwm_lvl),
    .rise_c (pwm_rise)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != '1)) return v + ONE;
    return v;
  endfunction

  assign meas_ok = duty_in_range(32'(hcnt_q)) && (pcnt_q == NOM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_FIRST;
    else     state_q <= state_d;
  end

  // Next state, counters and result registers; rise takes priority over timeout.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    to_d      = to_q;
    period_d  = period_cnt;
    high_d    = high_cnt;
    code_d    = duty_code;
    valid_d   = 1'b0;
    err_d     = err;
    timeout_d = timeout;

    if (!en) begin
      state_d = WAIT_FIRST;
      pcnt_d  = '0;
      hcnt_d  = '0;
      to_d    = '0;
    end else if (pwm_rise) begin
      state_d = MEASURE;
      pcnt_d  = ONE;
      hcnt_d  = ONE;
      to_d    = '0;
      if (state_q == MEASURE) begin
        period_d  = pcnt_q;
        high_d    = hcnt_q;
        code_d    = meas_ok ? CODE_W'(hcnt_q - ONE) : '0;
        err_d     = ~meas_ok;
        valid_d   = 1'b1;
        timeout_d = 1'b0;
      end
    end else begin
      if (state_q == MEASURE) begin
        pcnt_d = sat_inc(pcnt_q, 1'b1);
        hcnt_d = sat_inc(hcnt_q, pwm_lvl);
      end
      // Counter parks at TIMEOUT so a stuck input reports only once.
      if (to_q == TO_LAST) begin
        to_d      = TO_HOLD;
        state_d   = WAIT_FIRST;
        pcnt_d    = '0;
        hcnt_d    = '0;
        valid_d   = 1'b1;
        err_d     = 1'b1;
        timeout_d = 1'b1;
      end else if (to_q < TO_HOLD) begin
        to_d = to_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q     <= '0;
      hcnt_q     <= '0;
      to_q       <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      duty_code  <= '0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      pcnt_q     <= pcnt_d;
      hcnt_q     <= hcnt_d;
      to_q       <= to_d;
      period_cnt <= period_d;
      high_cnt   <= high_d;
      duty_code  <= code_d;
      meas_valid <= valid_d;
      err        <= err_d;
      timeout    <= timeout_d;
    end
  end

endmodule
